// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
// Multi-cycle adder: sums two WIDTH-bit operands plus a carry-in, CHUNK bits
// per clock, through a single CHUNK-wide adder slice and a registered carry.
// Handshake: start (accepted only while idle), busy during the operation,
// one-cycle done pulse when sum/cout/ovf are updated. Results hold until the
// next done. A cycle with done high is an idle cycle, so a new start there
// is accepted with no bubble.

module chunked_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Number of chunk steps per addition and a counter wide enough to hold N-1.
    localparam int N     = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(N) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Illegal geometries must not elaborate.
    generate
        if ((WIDTH < 1) || (CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
            $error("chunked_serial_adder: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Datapath registers.
    logic [WIDTH-1:0] r_a;        // operand A, shifted right one chunk per step
    logic [WIDTH-1:0] r_b;        // operand B, shifted right one chunk per step
    logic             r_carry;    // carry between chunk steps
    logic [WIDTH-1:0] r_acc;      // partial sum, filled from the MSB end
    logic [CNT_W-1:0] r_cnt;      // index of the chunk being added
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    // Next-value wires for the datapath registers.
    logic [WIDTH-1:0] w_a_nxt;
    logic [WIDTH-1:0] w_b_nxt;
    logic             w_carry_nxt;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_sum_nxt;
    logic             w_cout_nxt;
    logic             w_ovf_nxt;

    // The single adder slice and values derived from it.
    logic [CHUNK:0]   w_slice;       // {carry out, CHUNK sum bits}
    logic             w_slice_cout;  // carry out of the slice MSB
    logic             w_slice_cmsb;  // carry into the slice MSB
    logic [WIDTH-1:0] w_acc_shift;   // accumulator after shifting in this chunk
    logic             w_last;        // this step processes the final chunk

    // Low chunk of each operand plus the running carry.
    assign w_slice = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};

    assign w_slice_cout = w_slice[CHUNK];

    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out of the sum bit.
    // On the final chunk this is the carry into bit WIDTH-1 of the whole word.
    assign w_slice_cmsb = w_slice[CHUNK-1] ^ r_a[CHUNK-1] ^ r_b[CHUNK-1];

    // New chunk enters at the top; older chunks move down toward bit 0.
    // After N steps the first chunk has arrived at the LSB position.
    assign w_acc_shift = (r_acc >> CHUNK) | (WIDTH'(w_slice[CHUNK-1:0]) << (WIDTH - CHUNK));

    assign w_last = (r_state == S_RUN) && (r_cnt == LAST_CNT);

    // State register: IDLE/RUN, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: start launches RUN, the last chunk returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output/datapath logic: operand capture, per-chunk step, result commit.
    always_comb begin
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_carry_nxt = r_carry;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Accept: operands are only looked at on this edge.
                    w_a_nxt     = a;
                    w_b_nxt     = b;
                    w_carry_nxt = cin;
                    w_acc_nxt   = {WIDTH{1'b0}};
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                // One chunk step; start is ignored while running.
                w_a_nxt     = r_a >> CHUNK;
                w_b_nxt     = r_b >> CHUNK;
                w_carry_nxt = w_slice_cout;
                w_acc_nxt   = w_acc_shift;
                w_cnt_nxt   = r_cnt + CNT_W'(1);
                if (w_last) begin
                    // Publish the result; visible outputs change only here.
                    w_sum_nxt  = w_acc_shift;
                    w_cout_nxt = w_slice_cout;
                    w_ovf_nxt  = w_slice_cmsb ^ w_slice_cout;
                    w_done_nxt = 1'b1;
                    w_busy_nxt = 1'b0;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_acc   <= {WIDTH{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_carry <= w_carry_nxt;
            r_acc   <= w_acc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule
